axi_line_fill: RTL and testbench
================================

// Module: axi_line_fill
// PURPOSE
//  Cache-line refill engine: accepts a line-fill request from the I/D-cache miss path, issues one INCR read burst
//  on an axi master_no_id_read_only modport, gathers the 64-bit beats into a line buffer and returns the whole line.
//  Sits directly upstream of the AXI interconnect/memory slave; one outstanding burst, no IDs.
// PARAMETERS
//  LINE_BYTES  64  line size in bytes; power of two, 16..256; BEATS = LINE_BYTES/8, OFS = log2(LINE_BYTES)
// PORTS
//  clk         in   1                 clock, all logic on rising edge
//  rstn        in   1                 reset, synchronous, active-low
//  req_valid   in   1                 fill request valid
//  req_ready   out  1                 engine idle, can accept request
//  req_addr    in   32                miss address (any byte alignment)
//  resp_valid  out  1                 filled line valid
//  resp_ready  in   1                 consumer accepts line
//  resp_data   out  LINE_BYTES*8      line; beat i at bits [64*i+63:64*i]
//  resp_err    out  1                 any beat SLVERR/DECERR or burst length mismatch
//  mem         --   axi.master_no_id_read_only  araddr/arlen/arsize/arburst/arvalid out; arready in;
//                                     rdata/rresp/rlast/rvalid in; rready out
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE; arvalid=0, rready=0, resp_valid=0, resp_err=0, araddr=0, resp_data=0.
//  Constants: arlen=BEATS-1, arsize=3'd3, arburst=BURST_INCR (2'd1).
//  FSM IDLE -> AR -> R -> RESP -> IDLE:
//   IDLE: req_ready=1 only here. On req_valid&&req_ready: araddr <= {req_addr[31:OFS], OFS'b0}; clear line
//         buffer to 0, beat counter cnt <= 0, err <= 0; -> AR.
//   AR:   arvalid=1; araddr stable until arready. On arvalid&&arready -> R. arvalid never drops before arready.
//   R:    rready=1. On rvalid&&rready: if cnt<BEATS store rdata to beat cnt; cnt <= cnt+1 (saturate at BEATS);
//         err |= rresp[1] (SLVERR/DECERR; EXOKAY treated as OK). Burst ends only on rlast beat -> RESP.
//         rlast at cnt!=BEATS-1 (early or late) -> err=1; beats past BEATS-1 are dropped, not stored.
//   RESP: resp_valid=1; resp_data/resp_err stable until resp_ready. On resp_valid&&resp_ready -> IDLE
//         (req_ready=1 next cycle; no same-cycle req accept in RESP).
//  Latency: req accepted cycle N -> arvalid at N+1; rlast beat accepted cycle M -> resp_valid at M+1.
//   Min req-to-resp with arready=1 and back-to-back beats: BEATS+2 cycles.
//  All outputs registered except req_ready, rready (decoded from state). arvalid/rready never both 1.
//  Errors do not abort the burst; all beats are drained until rlast.
//  Reset mid-operation: FSM returns to IDLE, any in-flight burst abandoned; the memory slave shares rstn.
//  rvalid outside R state ignored (rready=0); rdata/rresp not sampled.
// TESTING
//  1 Basic: req_addr=0x8000_1234, arready=1, rdata=beat index i, rresp=OKAY -> araddr=0x8000_1200, arlen=7,
//    arsize=3, arburst=1; resp_data beat i = i; resp_err=0; resp_valid 10 cycles after req accept.
//  2 AR stall: arready low 5 cycles -> arvalid held 6 cycles, araddr constant, rready=0 throughout.
//  3 Error: beat 3 rresp=SLVERR, others OKAY -> all 8 beats stored, resp_err=1; next clean fill resp_err=0.
//  4 Length mismatch: rlast on beat 5 -> resp_valid next cycle, beats 6,7 = 0, resp_err=1; rlast on beat 9
//    -> beats 8,9 dropped, beats 0..7 intact, resp_err=1.
//  5 Backpressure: rvalid toggling 1-0, resp_ready low 4 cycles -> data correct, resp_* stable, req_ready=0
//    until handshake, then req_ready=1 following cycle.
//  6 Reset mid-burst: rstn=0 after beat 2 -> next cycle arvalid=rready=resp_valid=0, req_ready=1; new fill OK.

Source files
------------

// File: rtl/axi_line_fill_if.sv
// Read-only, ID-less AXI channel bundle: 32-bit address, 64-bit data.
interface axi;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master_no_id_read_only (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave_no_id_read_only (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_line_fill.sv
// Cache-line refill engine: one aligned INCR read burst per miss, beats gathered
// into a line buffer that is returned whole with a sticky error flag.
module axi_line_fill #(
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LINE_BYTES*8-1:0] resp_data,
  output logic                    resp_err,
  axi.master_no_id_read_only      mem
);

  localparam int unsigned BEATS      = LINE_BYTES / 8;
  localparam int unsigned OFS        = $clog2(LINE_BYTES);
  localparam int unsigned CW         = $clog2(BEATS + 1);
  localparam int unsigned LW         = LINE_BYTES * 8;
  localparam logic [1:0]  BURST_INCR = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_arvalid;
  logic [31:0]     r_araddr;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_line;
  logic            r_err;
  logic            r_resp_valid;

  logic            w_beat_err;
  logic            w_len_err;
  logic            w_unused_ofs;

  // SLVERR and DECERR poison the line; EXOKAY counts as a good beat.
  assign w_beat_err   = mem.rresp inside {2'b10, 2'b11};
  assign w_len_err    = mem.rlast && (r_cnt != CW'(BEATS - 1));
  assign w_unused_ofs = ^req_addr[OFS-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_araddr  <= {req_addr[31:OFS], {OFS{1'b0}}};
            r_line    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          if (mem.arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (mem.rvalid) begin
            // Beats beyond the line are drained but never stored.
            for (int unsigned i = 0; i < BEATS; i++) begin
              if (r_cnt == CW'(i)) begin
                r_line[i*64 +: 64] <= mem.rdata;
              end
            end
            if (r_cnt != CW'(BEATS)) begin
              r_cnt <= r_cnt + CW'(1);
            end
            r_err <= r_err | w_beat_err | w_len_err;
            if (mem.rlast) begin
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign mem.rready  = (r_state == S_R);
  assign mem.arvalid = r_arvalid;
  assign mem.araddr  = r_araddr;
  assign mem.arlen   = 8'(BEATS - 1);
  assign mem.arsize  = 3'd3;
  assign mem.arburst = BURST_INCR;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_line;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_axi_line_fill.sv
// Self-checking bench for axi_line_fill: bench-side AXI slave, scoreboard of
// expected lines pushed at request time and popped when the line comes back.
module tb_axi_line_fill;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = LINE_BYTES / 8;
  localparam int unsigned LW         = LINE_BYTES * 8;

  typedef struct {
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [LW-1:0] resp_data;
  logic          resp_err;

  axi mem_if ();

  axi_line_fill #(.LINE_BYTES(LINE_BYTES)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fill against the bench slave.
  task automatic do_fill(input logic [31:0] addr, input int nb, input int err_beat,
                         input int exok_beat, input int ar_stall, input bit gap,
                         input int resp_stall, input logic [31:0] seed);
    exp_t          e;
    exp_t          got_e;
    logic [LW-1:0] line;
    logic [31:0]   exp_addr;
    int            t0;
    int            waitc;
    int            exp_lat;

    line = '0;
    for (int i = 0; i < nb; i++) begin
      if (i < int'(BEATS)) line[i*64 +: 64] = {seed, 32'(i)};
    end
    e.data = line;
    e.err  = (err_beat >= 0 && err_beat < nb) || (nb != int'(BEATS));
    sb.push_back(e);
    exp_addr = addr & ~32'(LINE_BYTES - 1);
    exp_lat  = nb + 2 + ar_stall + (gap ? nb - 1 : 0);

    waitc = 0;
    while (!req_ready && waitc < 20) begin
      step();
      waitc++;
    end
    check("req_ready_idle", LW'(req_ready), LW'(1));

    req_valid = 1'b1;
    req_addr  = addr;
    t0        = cyc;
    step();
    req_valid = 1'b0;
    mem_if.arready = 1'b0;

    check("ar_addr", LW'(mem_if.araddr), LW'(exp_addr));
    check("ar_len_size_burst", LW'({mem_if.arlen, mem_if.arsize, mem_if.arburst}),
          LW'({8'd7, 3'd3, 2'd1}));
    check("req_ready_busy", LW'(req_ready), LW'(0));

    for (int k = 0; k < ar_stall; k++) begin
      check("ar_stall_hold", LW'({mem_if.arvalid, mem_if.rready, mem_if.araddr}),
            LW'({1'b1, 1'b0, exp_addr}));
      step();
    end
    mem_if.arready = 1'b1;
    check("ar_valid", LW'({mem_if.arvalid, mem_if.rready, mem_if.araddr}),
          LW'({1'b1, 1'b0, exp_addr}));
    step();
    mem_if.arready = 1'b0;

    for (int b = 0; b < nb; b++) begin
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = {seed, 32'(b)};
      mem_if.rresp  = (b == err_beat) ? 2'b10 : (b == exok_beat) ? 2'b01 : 2'b00;
      mem_if.rlast  = (b == nb - 1);
      check("r_phase", LW'({mem_if.arvalid, mem_if.rready}), LW'(2'b01));
      step();
      mem_if.rvalid = 1'b0;
      mem_if.rlast  = 1'b0;
      mem_if.rresp  = 2'b00;
      if (gap && b != nb - 1) step();
    end

    check("resp_latency", LW'(cyc - t0), LW'(exp_lat));
    waitc = 0;
    while (!resp_valid && waitc < 20) begin
      step();
      waitc++;
    end
    check("resp_valid", LW'(resp_valid), LW'(1));

    if (sb.size() == 0) begin
      check("sb_empty", LW'(0), LW'(1));
      return;
    end
    got_e = sb.pop_front();

    for (int k = 0; k < resp_stall; k++) begin
      check("resp_hold_data", resp_data, got_e.data);
      check("resp_hold_ctl", LW'({resp_valid, resp_err, req_ready}), LW'({1'b1, got_e.err, 1'b0}));
      step();
    end
    resp_ready = 1'b1;
    check("resp_data", resp_data, got_e.data);
    check("resp_err", LW'(resp_err), LW'(got_e.err));
    step();
    resp_ready = 1'b0;
    check("post_resp", LW'({resp_valid, req_ready}), LW'(2'b01));
  endtask

  initial begin
    rstn          = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    resp_ready    = 1'b0;
    mem_if.arready = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;
    mem_if.rresp  = 2'b00;
    mem_if.rlast  = 1'b0;
    step();
    step();
    check("rst_ctl", LW'({req_ready, mem_if.arvalid, mem_if.rready, resp_valid, resp_err}),
          LW'(5'b10000));
    check("rst_araddr", LW'(mem_if.araddr), LW'(0));
    check("rst_data", resp_data, LW'(0));
    rstn = 1'b1;
    step();

    do_fill(32'h8000_1234, 8, -1, -1, 0, 1'b0, 0, 32'h0);
    do_fill(32'h0000_40C8, 8, -1, -1, 5, 1'b0, 0, 32'h1);
    do_fill(32'h1000_0008, 8, 3, -1, 0, 1'b0, 0, 32'h2);
    do_fill(32'h1000_0040, 8, -1, 1, 0, 1'b0, 0, 32'h3);
    do_fill(32'h2000_007F, 6, -1, -1, 0, 1'b0, 0, 32'h4);
    do_fill(32'h2000_0080, 10, -1, -1, 0, 1'b0, 0, 32'h5);
    do_fill(32'h3000_0FFF, 8, -1, -1, 1, 1'b1, 4, 32'h6);

    // Abandon a burst after three beats.
    req_valid = 1'b1;
    req_addr  = 32'h4000_0100;
    step();
    req_valid = 1'b0;
    mem_if.arready = 1'b1;
    step();
    mem_if.arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = 64'hDEAD_0000_0000_0000 | 64'(b);
      step();
    end
    mem_if.rvalid = 1'b0;
    rstn = 1'b0;
    step();
    check("midrst_ctl", LW'({mem_if.arvalid, mem_if.rready, resp_valid, req_ready, resp_err}),
          LW'(5'b00010));
    check("midrst_data", resp_data, LW'(0));
    rstn = 1'b1;
    step();
    do_fill(32'h4000_0100, 8, -1, -1, 0, 1'b0, 0, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
